// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port RAM with byte enables, selectable read latency and RDW mode,
// defined cross-port collision handling and a post-reset init sweep.
module dual_port_ram_be #(
  parameter int DWIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AWIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE = 0,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_busy,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DWIDTH/8-1:0] a_be,
  input  logic [AWIDTH-1:0]   a_addr,
  input  logic [DWIDTH-1:0]   a_wdata,
  output logic [DWIDTH-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DWIDTH/8-1:0] b_be,
  input  logic [AWIDTH-1:0]   b_addr,
  input  logic [DWIDTH-1:0]   b_wdata,
  output logic [DWIDTH-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                collision
);
  localparam int NB = DWIDTH / 8;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [1:0] en, we, act, in_rng, wr, ret;
  logic [1:0][NB-1:0] be;
  logic [1:0][AWIDTH-1:0] addr;
  logic [1:0][DWIDTH-1:0] wdata, old, ret_data;
  logic [1:0][DWIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic [1:0] s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic col1_q, col1_d, col2_q, col2_d;

  function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] prev, wd,
                                               input logic [NB-1:0] bmask);
    logic [DWIDTH-1:0] r;
    r = prev;
    for (int i = 0; i < NB; i++) if (bmask[i]) r[8*i+:8] = wd[8*i+:8];
    return r;
  endfunction

  assign en = {b_en, a_en};
  assign we = {b_we, a_we};
  assign be = {b_be, a_be};
  assign addr = {b_addr, a_addr};
  assign wdata = {b_wdata, a_wdata};
  assign init_busy = state_q == INIT;
  assign a_rdata = RD_LATENCY == 2 ? s2_data_q[0] : s1_data_q[0];
  assign b_rdata = RD_LATENCY == 2 ? s2_data_q[1] : s1_data_q[1];
  assign a_rvalid = RD_LATENCY == 2 ? s2_valid_q[0] : s1_valid_q[0];
  assign b_rvalid = RD_LATENCY == 2 ? s2_valid_q[1] : s1_valid_q[1];
  assign collision = RD_LATENCY == 2 ? col2_q : col1_q;

  always_comb begin
    state_d = (state_q == INIT && ptr_q == LAST) ? RUN : state_q;
    ptr_d = state_q == INIT ? ptr_q + 1'b1 : '0;
    for (int p = 0; p < 2; p++) begin
      act[p] = state_q == RUN && en[p];
      in_rng[p] = {1'b0, addr[p]} < DEPTH_W;
      old[p] = in_rng[p] ? mem[addr[p]] : '0;
      wr[p] = act[p] && we[p] && in_rng[p];
      ret[p] = act[p] && (!we[p] || RDW_MODE != 2);
      // out-of-range returns stay zero even in write-first mode
      ret_data[p] = (we[p] && RDW_MODE == 0 && in_rng[p]) ? merge(old[p], wdata[p], be[p]) : old[p];
      s1_valid_d[p] = ret[p];
      s1_data_d[p] = ret[p] ? ret_data[p] : s1_data_q[p];
      s2_valid_d[p] = s1_valid_q[p];
      s2_data_d[p] = s1_valid_q[p] ? s1_data_q[p] : s2_data_q[p];
    end
    col1_d = &act && &in_rng && addr[0] == addr[1] && |we;
    col2_d = col1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q <= '0;
      s1_valid_q <= '0;
      s1_data_q <= '0;
      s2_valid_q <= '0;
      s2_data_q <= '0;
      col1_q <= 1'b0;
      col2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q <= s2_data_d;
      col1_q <= col1_d;
      col2_q <= col2_d;
    end
  end

  // B is written before A so A's lanes win on a same-address double write
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem[ptr_q] <= INIT_VALUE;
    else
      for (int p = 1; p >= 0; p--)
        if (wr[p])
          for (int i = 0; i < NB; i++)
            if (be[p][i]) mem[addr[p]][8*i+:8] <= wdata[p][8*i+:8];
  end
endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Parametrised true dual-port RAM with per-byte write enables. It has a selectable read latency, a selectable same-port read-during-write mode, defined cross-port collision behaviour, and a hardware init sweep after reset. It is the general-purpose on-chip buffer for the design, replacing single-port, fixed-width memories wherever two independent masters, or a writer and a reader, share storage.

## Interface
- DWIDTH, 32: data width in bits; must be a multiple of 8.
- DEPTH, 256: number of words; need not be a power of two.
- AWIDTH, 8: address width; requires 2^AWIDTH >= DEPTH.
- RD_LATENCY, 1: read latency in cycles; legal values are 1 or 2.
- RDW_MODE, 0: same-port read-during-write mode. 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
- INIT_VALUE, 0: word value written to every location by the init sweep.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_busy  out  1  high while the init sweep runs; port requests ignored.
- a_en  in  1  port A request.
- a_we  in  1  port A write (1) / read (0); qualified by a_en.
- a_be  in  DWIDTH/8  port A byte enables; bit i covers data[8i+7:8i].
- a_addr  in  AWIDTH  port A word address.
- a_wdata  in  DWIDTH  port A write data.
- a_rdata  out  DWIDTH  port A read data.
- a_rvalid  out  1  one-cycle pulse; a_rdata is valid.
- b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: port B, identical to port A.
- collision  out  1  one-cycle pulse; same-address access on both ports with at least one write.

## Operation
- FSM has two states, INIT and RUN. Reset forces INIT with the sweep pointer at 0.
- INIT: one location is written per clock with INIT_VALUE, ascending from 0 to DEPTH-1. After DEPTH-1 is written, the FSM moves to RUN. init_busy = (state == INIT).
- While in INIT, a_en and b_en are ignored: no writes and no rvalid.
- Write: en & we & addr < DEPTH. Only bytes with be[i] = 1 are updated. If be = 0, memory is unchanged but the access still counts as a write.
- Read: en & !we. Returns mem[addr]. Exactly one rvalid is produced per read.
- Same-port write returns data according to RDW_MODE:
  - WRITE_FIRST: rdata is the merged new word and rvalid pulses.
  - READ_FIRST: rdata is the pre-write word and rvalid pulses.
  - NO_CHANGE: rdata holds its value and no rvalid.
- Out-of-range address (addr >= DEPTH): writes are dropped. Reads return 0 with rvalid. This also applies to WRITE_FIRST/READ_FIRST write returns. No collision is flagged.
- Cross-port, same address, both ports writing: for each byte lane, A's data wins when both be bits are set. Otherwise the lane takes whichever port enables it. collision pulses.
- Cross-port, one port writes while the other reads the same address: the reader gets the pre-write word (read-first across ports). collision pulses.
- Both ports reading the same address: both get the data and there is no collision.

## Timing
- Reset values: a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, collision = 0, init_busy = 1.
- Sweep timing: the first rising edge after rst_n deasserts writes address 0, and edge number DEPTH writes DEPTH-1. init_busy falls after edge DEPTH. The first request is accepted at edge DEPTH+1.
- Read latency: a request sampled at edge k updates rdata/rvalid after edge k + RD_LATENCY - 1.
  - RD_LATENCY = 1: data visible in the cycle following the sampling edge.
  - RD_LATENCY = 2: adds an output register stage, one cycle later.
  - Either way, one request per port per cycle at full throughput, with no stalls.
- Each rvalid is high for exactly one cycle per qualifying access. Between accesses, rdata holds its last value.
- collision is registered and pulses with the same latency as rvalid, relative to the colliding edge.
- Reset mid-operation clears the pipeline, rvalid and collision immediately, which drops in-flight reads. The FSM returns to INIT and the sweep restarts at address 0. Memory is not cleared asynchronously; only the sweep overwrites it.

## Test plan
- Reset with DEPTH = 256, INIT_VALUE = 32'hA5A5A5A5:
  - init_busy is high for exactly 256 edges.
  - Requests issued during INIT produce no rvalid.
  - Reading addresses 0, 128 and 255 afterwards returns A5A5A5A5.
- Byte enables: A writes 32'h11223344 to addr 5 with be = 4'b0101 over prior A5A5A5A5. B then reads addr 5 and gets A522A544, exactly RD_LATENCY cycles after the request edge. Repeat for RD_LATENCY = 1 and 2.
- RDW_MODE: A writes 32'hDEADBEEF to addr 7, which holds 0.
  - WRITE_FIRST: a_rdata = DEADBEEF with a_rvalid.
  - READ_FIRST: a_rdata = 0 with a_rvalid.
  - NO_CHANGE: no a_rvalid and a_rdata unchanged.
- Collisions on addr 9:
  - A writes 0xFFFFFFFF with be = 4'b0011 and B writes 0 with be = 4'b1111 in the same cycle. A later read returns 0000FFFF and collision pulses once.
  - A writes while B reads addr 9: B gets the old word and collision pulses.
- Boundaries with DEPTH = 200, AWIDTH = 8: a write to addr 200 is dropped, and a read of addr 200 returns 0 with rvalid. Back-to-back reads on both ports every cycle for 100 cycles give 100 rvalids per port.
- Reset mid-operation:
  - Assert rst_n low during INIT at sweep address 100, and again with a read in flight at RD_LATENCY = 2. The outputs clear at once, the dropped read never produces rvalid, and the sweep restarts at 0 with init_busy high for a full 256 cycles.
